// File: rtl/axi_txn_tracker_if.sv
// Slave-side AXI handshake bundle observed by the transaction tracker.
// The master modport is the side that drives the muxed bus; the slave
// modport is the passive observer (the tracker).
interface axi_txn_tracker_if #(
  parameter int LEN_W = 4
) ();
  logic             awvalid;
  logic             awready;
  logic [LEN_W-1:0] awlen;
  logic             wvalid;
  logic             wready;
  logic             wlast;
  logic             bvalid;
  logic             bready;
  logic [1:0]       bresp;
  logic             arvalid;
  logic             arready;
  logic [LEN_W-1:0] arlen;
  logic             rvalid;
  logic             rready;
  logic             rlast;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awready, awlen, wvalid, wready, wlast,
           bvalid, bready, bresp, arvalid, arready, arlen,
           rvalid, rready, rlast, rresp
  );

  modport slave (
    input  awvalid, awready, awlen, wvalid, wready, wlast,
           bvalid, bready, bresp, arvalid, arready, arlen,
           rvalid, rready, rlast, rresp
  );
endinterface

// File: rtl/axi_txn_tracker.sv
// Transaction tracker on the granted path between the round-robin arbiter
// and the slave. Latches the grant as owner, follows one AXI transaction
// (write or read burst), and pulses txn_done to re-enable arbitration.
// Slave errors, LAST mismatches and stalls are reported via err_code.
module axi_txn_tracker #(
  parameter int LEN_W   = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             gnt,
  axi_txn_tracker_if.slave       bus,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic [LEN_W:0]         beats_left,
  output logic                   txn_done,
  output logic                   txn_err,
  output logic [1:0]             err_code
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [LEN_W:0]  BEAT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0]  BEAT_ZERO = {(LEN_W+1){1'b0}};
  localparam logic [TO_W-1:0] TIMER_ONE = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TIMER_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  // Error encoding with priority timeout > LAST mismatch > slave error.
  function automatic logic [1:0] err_encode(input logic to, input logic mis, input logic slv);
    logic [1:0] code;
    if (to) begin
      code = 2'b11;
    end else if (mis) begin
      code = 2'b10;
    end else if (slv) begin
      code = 2'b01;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  state_t          state_r;
  logic [TO_W-1:0] timer_r;
  logic            mis_r;
  logic            slv_r;

  logic       hs_aw_s;
  logic       hs_w_s;
  logic       hs_b_s;
  logic       hs_ar_s;
  logic       hs_r_s;
  logic       hs_any_s;
  logic       beat_last_s;
  logic       w_mis_s;
  logic       r_mis_s;
  logic       r_slv_s;
  logic       gnt_ok_s;
  logic       watched_s;
  logic       timeout_s;
  logic [1:0] done_code_s;
  logic       unused_resp_s;

  // Handshake decode, per-beat checks and the completion error code.
  always_comb begin
    hs_aw_s       = bus.awvalid & bus.awready;
    hs_w_s        = bus.wvalid  & bus.wready;
    hs_b_s        = bus.bvalid  & bus.bready;
    hs_ar_s       = bus.arvalid & bus.arready;
    hs_r_s        = bus.rvalid  & bus.rready;
    hs_any_s      = hs_aw_s | hs_w_s | hs_b_s | hs_ar_s | hs_r_s;
    beat_last_s   = (beats_left == BEAT_ONE);
    w_mis_s       = hs_w_s & (bus.wlast != beat_last_s);
    r_mis_s       = hs_r_s & (bus.rlast != beat_last_s);
    r_slv_s       = hs_r_s & bus.rresp[1];
    gnt_ok_s      = (gnt == 2'b01) || (gnt == 2'b10);
    unused_resp_s = bus.bresp[0] ^ bus.rresp[0];
    watched_s     = (state_r == ST_ADDR) || (state_r == ST_WDATA) ||
                    (state_r == ST_WRESP) || (state_r == ST_RDATA);
    timeout_s     = watched_s && !hs_any_s && (timer_r == TIMER_LAST);
    case (state_r)
      ST_WRESP: done_code_s = err_encode(1'b0, mis_r, slv_r | bus.bresp[1]);
      ST_RDATA: done_code_s = err_encode(1'b0, mis_r | r_mis_s, slv_r | r_slv_s);
      default:  done_code_s = err_encode(1'b0, mis_r, slv_r);
    endcase
  end

  // Stall timer: counts handshake-free cycles while a transaction is open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r <= TIMER_ZERO;
    end else if (!watched_s || hs_any_s || timeout_s) begin
      timer_r <= TIMER_ZERO;
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Transaction FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      owner      <= 2'b00;
      busy       <= 1'b0;
      beats_left <= BEAT_ZERO;
      txn_done   <= 1'b0;
      txn_err    <= 1'b0;
      err_code   <= 2'b00;
      mis_r      <= 1'b0;
      slv_r      <= 1'b0;
    end else if (timeout_s) begin
      state_r    <= ST_DONE;
      beats_left <= BEAT_ZERO;
      txn_done   <= 1'b1;
      txn_err    <= 1'b1;
      err_code   <= err_encode(1'b1, mis_r, slv_r);
    end else begin
      case (state_r)
        ST_IDLE: begin
          txn_done <= 1'b0;
          txn_err  <= 1'b0;
          if (gnt_ok_s) begin
            owner   <= gnt;
            busy    <= 1'b1;
            mis_r   <= 1'b0;
            slv_r   <= 1'b0;
            state_r <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (hs_aw_s) begin
            beats_left <= {1'b0, bus.awlen} + BEAT_ONE;
            mis_r      <= hs_ar_s;
            state_r    <= ST_WDATA;
          end else if (hs_ar_s) begin
            beats_left <= {1'b0, bus.arlen} + BEAT_ONE;
            state_r    <= ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (hs_w_s) begin
            beats_left <= beats_left - BEAT_ONE;
            mis_r      <= mis_r | w_mis_s;
            if (beat_last_s) begin
              state_r <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (hs_b_s) begin
            slv_r    <= slv_r | bus.bresp[1];
            txn_done <= 1'b1;
            txn_err  <= (done_code_s != 2'b00);
            err_code <= done_code_s;
            state_r  <= ST_DONE;
          end
        end
        ST_RDATA: begin
          if (hs_r_s) begin
            beats_left <= beats_left - BEAT_ONE;
            mis_r      <= mis_r | r_mis_s;
            slv_r      <= slv_r | r_slv_s;
            if (beat_last_s) begin
              txn_done <= 1'b1;
              txn_err  <= (done_code_s != 2'b00);
              err_code <= done_code_s;
              state_r  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          owner    <= 2'b00;
          busy     <= 1'b0;
          txn_done <= 1'b0;
          txn_err  <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          owner    <= 2'b00;
          busy     <= 1'b0;
          txn_done <= 1'b0;
          txn_err  <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_tracker.sv
// Directed testbench for axi_txn_tracker: write/read bursts, slave error,
// LAST mismatch, simultaneous AW/AR, maximum burst length, timeout abort,
// asynchronous reset mid-burst and grant filtering.
module tb_axi_txn_tracker;
  localparam int LEN_W   = 4;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 200;

  logic             clk;
  logic             rst;
  logic [1:0]       gnt;
  logic [1:0]       owner;
  logic             busy;
  logic [LEN_W:0]   beats_left;
  logic             txn_done;
  logic             txn_err;
  logic [1:0]       err_code;

  int n_tests;
  int n_fail;

  axi_txn_tracker_if #(.LEN_W(LEN_W)) bus ();

  axi_txn_tracker #(.LEN_W(LEN_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .gnt        (gnt),
    .bus        (bus.slave),
    .owner      (owner),
    .busy       (busy),
    .beats_left (beats_left),
    .txn_done   (txn_done),
    .txn_err    (txn_err),
    .err_code   (err_code)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.awvalid = 1'b0; bus.awready = 1'b0; bus.awlen = 4'd0;
    bus.wvalid  = 1'b0; bus.wready  = 1'b0; bus.wlast = 1'b0;
    bus.bvalid  = 1'b0; bus.bready  = 1'b0; bus.bresp = 2'b00;
    bus.arvalid = 1'b0; bus.arready = 1'b0; bus.arlen = 4'd0;
    bus.rvalid  = 1'b0; bus.rready  = 1'b0; bus.rlast = 1'b0;
    bus.rresp   = 2'b00;
  endtask

  // Directed stimulus sequence.
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    gnt = 2'b00;
    bus_idle();
    tick(); tick();
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_beats", 32'(beats_left), 32'd0);
    chk("rst_done", 32'(txn_done), 32'd0);
    chk("rst_err", 32'(txn_err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst = 1'b1;
    tick();

    // Write burst awlen=3, clean; gnt toggles while busy.
    gnt = 2'b01;
    tick();
    chk("t1_owner_addr", 32'(owner), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    gnt = 2'b00;
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = 4'd3;
    tick();
    chk("t1_beats_init", 32'(beats_left), 32'd4);
    bus_idle();
    gnt = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = (i == 3);
      tick();
      chk("t1_beats", 32'(beats_left), 32'(3 - i));
      chk("t1_owner_hold", 32'(owner), 32'd1);
    end
    bus_idle();
    gnt = 2'b00;
    bus.bvalid = 1'b1; bus.bready = 1'b1; bus.bresp = 2'b00;
    tick();
    chk("t1_done", 32'(txn_done), 32'd1);
    chk("t1_err", 32'(txn_err), 32'd0);
    chk("t1_code", 32'(err_code), 32'd0);
    chk("t1_owner_done", 32'(owner), 32'd1);
    bus_idle();
    tick();
    chk("t1_done_clr", 32'(txn_done), 32'd0);
    chk("t1_owner_idle", 32'(owner), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Single-beat read with SLVERR.
    gnt = 2'b10;
    tick();
    chk("t2_owner", 32'(owner), 32'd2);
    gnt = 2'b00;
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd0;
    tick();
    chk("t2_beats", 32'(beats_left), 32'd1);
    bus_idle();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1; bus.rresp = 2'b10;
    tick();
    chk("t2_done", 32'(txn_done), 32'd1);
    chk("t2_err", 32'(txn_err), 32'd1);
    chk("t2_code", 32'(err_code), 32'd1);
    chk("t2_beats_end", 32'(beats_left), 32'd0);
    bus_idle();
    tick();
    chk("t2_owner_idle", 32'(owner), 32'd0);
    chk("t2_err_clr", 32'(txn_err), 32'd0);
    chk("t2_code_held", 32'(err_code), 32'd1);

    // Early wlast on beat 2; B held high throughout to catch early WRESP.
    gnt = 2'b01;
    tick();
    gnt = 2'b00;
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = 4'd3;
    tick();
    bus_idle();
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = (i == 1);
      tick();
      chk("t3_no_early_done", 32'(txn_done), 32'd0);
    end
    bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
    tick();
    chk("t3_done", 32'(txn_done), 32'd1);
    chk("t3_err", 32'(txn_err), 32'd1);
    chk("t3_code", 32'(err_code), 32'd2);
    bus_idle();
    tick();

    // AW and AR together: write wins, flagged as mismatch.
    gnt = 2'b10;
    tick();
    gnt = 2'b00;
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = 4'd0;
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd5;
    tick();
    chk("t4_beats_aw", 32'(beats_left), 32'd1);
    bus_idle();
    bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = 1'b1;
    tick();
    chk("t4_wresp_wait", 32'(txn_done), 32'd0);
    bus_idle();
    bus.bvalid = 1'b1; bus.bready = 1'b1;
    tick();
    chk("t4_done", 32'(txn_done), 32'd1);
    chk("t4_code", 32'(err_code), 32'd2);
    bus_idle();
    tick();

    // Maximum burst awlen=15 -> 16 beats, DECERR response.
    gnt = 2'b01;
    tick();
    gnt = 2'b00;
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = 4'd15;
    tick();
    chk("t5_beats_max", 32'(beats_left), 32'd16);
    bus_idle();
    for (int i = 0; i < 16; i++) begin
      bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = (i == 15);
      tick();
    end
    chk("t5_beats_zero", 32'(beats_left), 32'd0);
    bus_idle();
    bus.bvalid = 1'b1; bus.bready = 1'b1; bus.bresp = 2'b11;
    tick();
    chk("t5_done", 32'(txn_done), 32'd1);
    chk("t5_code", 32'(err_code), 32'd1);
    bus_idle();
    tick();

    // Timeout: AW only, then silence.
    gnt = 2'b01;
    tick();
    gnt = 2'b00;
    bus.awvalid = 1'b1; bus.awready = 1'b1; bus.awlen = 4'd0;
    tick();
    bus_idle();
    repeat (TIMEOUT - 1) tick();
    chk("t6_not_yet", 32'(txn_done), 32'd0);
    chk("t6_still_busy", 32'(busy), 32'd1);
    tick();
    chk("t6_done", 32'(txn_done), 32'd1);
    chk("t6_err", 32'(txn_err), 32'd1);
    chk("t6_code", 32'(err_code), 32'd3);
    chk("t6_beats", 32'(beats_left), 32'd0);
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_owner", 32'(owner), 32'd0);

    // Asynchronous reset in the middle of a read burst.
    gnt = 2'b10;
    tick();
    gnt = 2'b00;
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd2;
    tick();
    bus_idle();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b0;
    tick();
    chk("t7_beats_mid", 32'(beats_left), 32'd2);
    bus_idle();
    #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_owner", 32'(owner), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_beats", 32'(beats_left), 32'd0);
    chk("t7_rst_code", 32'(err_code), 32'd0);
    chk("t7_rst_done", 32'(txn_done), 32'd0);
    tick();
    rst = 1'b1;
    gnt = 2'b10;
    tick();
    chk("t7_regrant", 32'(owner), 32'd2);
    chk("t7_regrant_busy", 32'(busy), 32'd1);
    gnt = 2'b00;
    bus.arvalid = 1'b1; bus.arready = 1'b1; bus.arlen = 4'd0;
    tick();
    bus_idle();
    bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
    tick();
    chk("t7_done", 32'(txn_done), 32'd1);
    chk("t7_code", 32'(err_code), 32'd0);
    bus_idle();
    tick();

    // gnt=11 is not a valid grant.
    gnt = 2'b11;
    tick();
    chk("t8_busy", 32'(busy), 32'd0);
    chk("t8_owner", 32'(owner), 32'd0);
    tick();
    chk("t8_busy2", 32'(busy), 32'd0);
    gnt = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
